// File: rtl/pfr_pll_seq_pkg.sv
// Shared types and helpers for the PLL / domain reset sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package pfr_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 4096;
    localparam int DEF_LOCK_STABLE_CYCLES  = 64;
    localparam int DEF_STAGE_DELAY_CYCLES  = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The shared down-counter is loaded with (cycles - 1), so it must hold
    // the largest cycle parameter; +1 keeps a single-cycle setting legal.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        return $clog2(max4(a, b, c, d) + 1);
    endfunction

    localparam int SEQ_CNT_W = cnt_width(DEF_PLL_RST_CYCLES, DEF_LOCK_TIMEOUT_CYCLES,
                                         DEF_LOCK_STABLE_CYCLES, DEF_STAGE_DELAY_CYCLES);

endpackage

// File: rtl/synchronizer.sv
// Generic multi-flop synchronizer for bringing asynchronous levels into clk.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; level signals only, no handshake.
// Ports: clk, rst_n (async active-low, clears the chain), d (async in), q (synchronized out).
module synchronizer #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pfr_pll_reset_sequencer.sv
// PLL reset / lock qualification and staggered per-domain reset release, on the reference clock.
// Latency: pll_locked reaches decisions after 2 sync flops; every output is registered (one more cycle).
// Backpressure: none; single-cycle pulse inputs are acted on in the cycle they are seen.
// Ports: clk, resetn (async active-low), pll_locked (async), relock_req / clear_status (pulses);
//        pll_reset, domain_rst_n[NUM_DOMAINS], sys_ready, pll_fail, lock_lost_sticky, retry_count.
module pfr_pll_reset_sequencer
    import pfr_pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int STAGE_DELAY_CYCLES  = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             pll_locked,
    input  logic                             relock_req,
    input  logic                             clear_status,
    output logic                             pll_reset,
    output logic [NUM_DOMAINS-1:0]           domain_rst_n,
    output logic                             sys_ready,
    output logic                             pll_fail,
    output logic                             lock_lost_sticky,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, STAGE_DELAY_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int IW = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] RST_LOAD    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LOAD = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LOAD  = CW'(STAGE_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [IW-1:0] IDX_ALL     = IW'(NUM_DOMAINS);

    seq_state_t     state;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idx;
    logic           lock_s;
    logic [RW-1:0]  retry_base;
    logic [RW-1:0]  retry_inc;

    synchronizer #(
        .STAGES (2),
        .WIDTH  (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // A clear in the same cycle as a timeout is applied first, so the
    // increment lands on zero and the result is 1.
    always_comb begin
        retry_base = clear_status ? '0 : retry_count;
        retry_inc  = (retry_base == RETRY_MAX) ? retry_base : retry_base + RW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= PLL_RST;
            cnt              <= RST_LOAD;
            idx              <= '0;
            pll_reset        <= 1'b1;
            domain_rst_n     <= '0;
            sys_ready        <= 1'b0;
            pll_fail         <= 1'b0;
            lock_lost_sticky <= 1'b0;
            retry_count      <= '0;
        end else begin
            // Later assignments in this block override the clear, which
            // gives a same-cycle sticky set or retry increment priority.
            if (clear_status) begin
                lock_lost_sticky <= 1'b0;
                retry_count      <= '0;
            end

            if (relock_req) begin
                state        <= PLL_RST;
                cnt          <= RST_LOAD;
                idx          <= '0;
                pll_reset    <= 1'b1;
                domain_rst_n <= '0;
                sys_ready    <= 1'b0;
                pll_fail     <= 1'b0;
                if (state == FAIL) begin
                    retry_count <= '0;
                end
            end else begin
                case (state)
                    PLL_RST: begin
                        if (cnt == '0) begin
                            state     <= WAIT_LOCK;
                            cnt       <= TIMEOUT_LOAD;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            cnt   <= STABLE_LOAD;
                        end else if (cnt == '0) begin
                            retry_count <= retry_inc;
                            pll_reset   <= 1'b1;
                            if (retry_inc == RETRY_MAX) begin
                                state    <= FAIL;
                                pll_fail <= 1'b1;
                            end else begin
                                state <= PLL_RST;
                                cnt   <= RST_LOAD;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    STABLE: begin
                        // Any dropout restarts qualification; not a retry.
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= TIMEOUT_LOAD;
                        end else if (cnt == '0) begin
                            state        <= RELEASE;
                            cnt          <= STAGE_LOAD;
                            idx          <= IW'(1);
                            domain_rst_n <= NUM_DOMAINS'(1);
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    RELEASE: begin
                        if (!lock_s) begin
                            state        <= PLL_RST;
                            cnt          <= RST_LOAD;
                            idx          <= '0;
                            pll_reset    <= 1'b1;
                            domain_rst_n <= '0;
                        end else if (idx == IDX_ALL) begin
                            state     <= RUN;
                            sys_ready <= 1'b1;
                        end else if (cnt == '0) begin
                            // OR-in keeps earlier bits set, so release order holds.
                            domain_rst_n <= domain_rst_n | (NUM_DOMAINS'(1) << idx);
                            idx          <= idx + IW'(1);
                            cnt          <= STAGE_LOAD;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end

                    RUN: begin
                        if (!lock_s) begin
                            state            <= PLL_RST;
                            cnt              <= RST_LOAD;
                            idx              <= '0;
                            pll_reset        <= 1'b1;
                            domain_rst_n     <= '0;
                            sys_ready        <= 1'b0;
                            lock_lost_sticky <= 1'b1;
                        end
                    end

                    FAIL: begin
                        // Terminal: outputs hold until relock_req or resetn.
                    end

                    default: begin
                        state        <= PLL_RST;
                        cnt          <= RST_LOAD;
                        idx          <= '0;
                        pll_reset    <= 1'b1;
                        domain_rst_n <= '0;
                        sys_ready    <= 1'b0;
                        pll_fail     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pfr_pll_reset_sequencer.md
Name: pfr_pll_reset_sequencer

Overview:
- Controller for the system PLL and its per-domain reset release. Runs on the free-running reference clock.
- Pulses the PLL reset and waits for a qualified lock, with timeout and a bounded retry count.
- Releases per-domain reset enables one at a time, in a fixed order, with a stagger between them.
- Re-sequences on loss of lock or on a software relock request. Reports status and a fatal-fail flag to the PFR management logic.

Parameters:
- NUM_DOMAINS, 4, number of domain reset enables (index 0 released first: clk50M, sys_clk, clk2M, spi_clk).
- PLL_RST_CYCLES, 16, width of the pll_reset pulse in clk cycles.
- LOCK_TIMEOUT_CYCLES, 4096, maximum wait for a synchronized lock before a retry.
- LOCK_STABLE_CYCLES, 64, number of consecutive locked cycles that qualify a lock.
- STAGE_DELAY_CYCLES, 8, spacing between successive domain releases.
- MAX_RETRIES, 3, number of failed lock attempts before FAIL.

Ports:
- clk  in  1  reference clock (free-running, independent of the PLL).
- resetn  in  1  asynchronous active-low reset.
- pll_locked  in  1  raw PLL lock, asynchronous to clk.
- relock_req  in  1  single-cycle pulse; restart the sequence from PLL_RST.
- clear_status  in  1  single-cycle pulse; clears lock_lost_sticky and retry_count.
- pll_reset  out  1  PLL areset, active-high.
- domain_rst_n  out  NUM_DOMAINS  per-domain reset enable, active-low.
- sys_ready  out  1  high only in RUN.
- pll_fail  out  1  high only in FAIL.
- lock_lost_sticky  out  1  set on loss of lock while in RUN.
- retry_count  out  $clog2(MAX_RETRIES+1)  number of failed lock attempts.

Behaviour:
- Reset values: pll_reset=1, domain_rst_n=0, sys_ready=0, pll_fail=0, lock_lost_sticky=0, retry_count=0. State=PLL_RST.
- pll_locked goes through a 2-flop synchronizer, giving lock_s. All decisions use lock_s.
- One shared down-counter serves every timed state. It is loaded on state entry.
- PLL_RST:
  - pll_reset=1, domain_rst_n all 0.
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0.
  - lock_s=1: go to STABLE.
  - LOCK_TIMEOUT_CYCLES cycles elapse with no lock: retry_count++.
  - If the new retry_count equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- STABLE:
  - Requires LOCK_STABLE_CYCLES consecutive cycles of lock_s=1, then go to RELEASE with stage index=0.
  - lock_s=0 at any point: return to WAIT_LOCK with the timeout reloaded. This does not count as a retry.
- RELEASE:
  - On entry, and after every STAGE_DELAY_CYCLES, set domain_rst_n[idx]=1 and increment idx.
  - Once all NUM_DOMAINS are released, go to RUN on the following cycle.
  - Released bits stay at 1.
- RUN: sys_ready=1.
- Loss of lock in RELEASE or RUN (lock_s=0):
  - Same cycle: all domain_rst_n=0 and sys_ready=0, registered.
  - lock_lost_sticky=1 (RUN only), then go to PLL_RST.
  - retry_count is unchanged.
- FAIL:
  - pll_reset=1, domain_rst_n all 0, pll_fail=1.
  - Terminal. Only relock_req or resetn leaves FAIL.
- relock_req:
  - Valid in any state. The next state is PLL_RST and all domain resets are asserted.
  - Leaving FAIL via relock_req also clears retry_count.
- Simultaneous events:
  - relock_req has priority over loss-of-lock and over timeout.
  - clear_status and a sticky set in the same cycle: the set wins.
  - clear_status with a retry increment in the same cycle: the increment wins and the result is 1.
- retry_count saturates at MAX_RETRIES.
- All outputs are registered. There is no combinational path from input to output.
- Domain reset ordering guarantee: domain_rst_n[k] never rises before domain_rst_n[k-1].
- Per-domain synchronization of domain_rst_n is done downstream and is not part of this block.

Decomposition:
- Package pfr_pll_seq_pkg:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
  - counter-width localparam, derived from the maximum of the cycle parameters.
- Reuse the existing synchronizer module (STAGES=2, WIDTH=1) for pll_locked. No other sub-module.

Test Plan:
- Clean start:
  - Stimulus: release resetn; pll_locked rises 100 cycles after pll_reset falls.
  - Response: pll_reset high for exactly 16 cycles. domain_rst_n goes 0001, 0011, 0111, 1111 with 8-cycle spacing. sys_ready rises 1 cycle after 1111.
- Lock glitch in STABLE:
  - Stimulus: drop pll_locked for 1 cycle at stable count 30.
  - Response: returns to WAIT_LOCK, retry_count stays 0, STABLE restarts and needs a full 64 cycles.
- Timeouts:
  - Stimulus: pll_locked held 0.
  - Response: 3 pll_reset pulses, retry_count goes 1, 2, then 3. pll_fail=1 after the third 4096-cycle timeout, with pll_reset held high.
- Loss of lock in RUN:
  - Stimulus: pll_locked falls while in RUN.
  - Response: within 3 cycles (sync plus register), domain_rst_n=0000, sys_ready=0, lock_lost_sticky=1, a new 16-cycle pll_reset pulse follows, and retry_count is unchanged.
- Recovery from FAIL:
  - Stimulus: relock_req pulse while in FAIL.
  - Response: pll_fail=0, retry_count=0, PLL_RST entered. With lock present, RUN is reached.
- Mid-operation reset and clear:
  - Stimulus: assert resetn during RELEASE at idx=2, then pulse clear_status in the same cycle as a sticky set.
  - Response: all outputs return to reset values asynchronously. The sticky remains 1.
